// File: rtl/min_max_seq.sv
// min_max_seq: registered LED bar-graph driver with range/bar/peak modes,
// an internal blink divider and a peak-hold timer.
module min_max_seq #(
  parameter int VALSIZE     = 4,
  parameter int BLINK_DIV   = 25000000,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [2:0]              com_i,
  input  logic [VALSIZE-1:0]      min_i,
  input  logic [VALSIZE-1:0]      max_i,
  input  logic [VALSIZE-1:0]      val_i,
  input  logic                    val_valid_i,
  input  logic                    peak_clr_i,
  output logic [2**VALSIZE-1:0]   leds_o,
  output logic                    blink_o
);

  localparam int NLED = 2**VALSIZE;
  localparam int BW   = $clog2(BLINK_DIV + 1);
  localparam int HW   = $clog2(HOLD_CYCLES + 1);

  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [HW-1:0] HOLD_INIT  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_ONE   = HW'(1);

  logic [VALSIZE-1:0] val_q, val_d;
  logic [VALSIZE-1:0] peak_q, peak_d;
  logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;
  logic [NLED-1:0]    leds_q, leds_d;

  // Widened copies so LED index compares never wrap at 2**VALSIZE-1
  logic [VALSIZE:0] v_x, mn_x, mx_x, pk_x;
  logic             in_range;

  assign v_x      = {1'b0, val_q};
  assign mn_x     = {1'b0, min_i};
  assign mx_x     = {1'b0, max_i};
  assign pk_x     = {1'b0, peak_q};
  assign in_range = (min_i <= val_q) && (val_q <= max_i);

  // Value register: load on strobe, otherwise hold
  always_comb begin
    val_d = val_q;
    if (val_valid_i) val_d = val_i;
  end

  // Blink divider: count 0..BLINK_DIV-1, toggle phase on wrap
  always_comb begin
    blink_cnt_d = blink_cnt_q + BW'(1);
    blink_d     = blink_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  // Peak/hold: clear beats capture; an expiring hold falls back to the current value
  always_comb begin
    peak_d     = peak_q;
    hold_cnt_d = hold_cnt_q;
    if (peak_clr_i) begin
      peak_d     = '0;
      hold_cnt_d = '0;
    end else if (val_valid_i && (val_i >= peak_q)) begin
      peak_d     = val_i;
      hold_cnt_d = HOLD_INIT;
    end else if (hold_cnt_q > HOLD_ONE) begin
      hold_cnt_d = hold_cnt_q - HOLD_ONE;
    end else if (hold_cnt_q == HOLD_ONE) begin
      hold_cnt_d = '0;
      peak_d     = val_q;
    end
  end

  // LED pattern from live mode/bounds and the current registers
  always_comb begin
    logic [VALSIZE:0] idx;
    leds_d = '0;
    idx    = '0;
    for (int k = 0; k < NLED; k++) begin
      idx = k[VALSIZE:0];
      case (com_i)
        3'b000: if (in_range)
                  leds_d[k] = ((idx >= mn_x) && (idx <= v_x)) ||
                              ((idx > v_x) && (idx <= mx_x) && blink_q);
        3'b001: leds_d[k] = (idx <= v_x);
        3'b011: leds_d[k] = 1'b1;
        3'b100: leds_d[k] = (idx <= v_x) || (idx == pk_x);
        default: leds_d[k] = 1'b0;
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      val_q       <= '0;
      peak_q      <= '0;
      hold_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      leds_q      <= '0;
    end else begin
      val_q       <= val_d;
      peak_q      <= peak_d;
      hold_cnt_q  <= hold_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      leds_q      <= leds_d;
    end
  end

  assign leds_o  = leds_q;
  assign blink_o = blink_q;

endmodule

// File: tb/tb_min_max_seq.sv
// tb_min_max_seq: scoreboard bench for min_max_seq (VALSIZE=4, BLINK_DIV=4, HOLD=8).
module tb_min_max_seq;

  localparam int BDIV = 4;
  localparam int HOLD = 8;

  logic        clk;
  logic        rst, vv, pc;
  logic [2:0]  com;
  logic [3:0]  mn, mx, vl;
  logic [15:0] leds_o;
  logic        blink_o;

  min_max_seq #(.VALSIZE(4), .BLINK_DIV(BDIV), .HOLD_CYCLES(HOLD)) dut (
    .clk_i(clk), .rst_i(rst), .com_i(com), .min_i(mn), .max_i(mx),
    .val_i(vl), .val_valid_i(vv), .peak_clr_i(pc),
    .leds_o(leds_o), .blink_o(blink_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          tgt;
    logic [15:0] leds;
    logic        blink;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // reference state
  int   m_val, m_peak, m_hold, m_bcnt;
  logic m_blink;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int upto(input int n);
    return (n < 0) ? 0 : ((1 << (n + 1)) - 1);
  endfunction

  function automatic logic [15:0] leds_fn(input logic [2:0] c, input int lo, input int hi,
                                          input int v, input logic b, input int pk);
    int r;
    r = 0;
    case (c)
      3'd0: if (lo <= v && v <= hi) begin
              r = upto(v) & ~upto(lo - 1);
              if (b) r = r | (upto(hi) & ~upto(v));
            end
      3'd1: r = upto(v);
      3'd3: r = 32'hFFFF;
      3'd4: r = upto(v) | (1 << pk);
      default: r = 0;
    endcase
    return 16'(r);
  endfunction

  // One clock: predict this edge's outputs, push, then retire due entries
  task automatic tick();
    exp_t e;
    if (rst) begin
      m_val = 0; m_peak = 0; m_hold = 0; m_bcnt = 0; m_blink = 1'b0;
      e.leds = '0; e.blink = 1'b0;
    end else begin
      e.leds = leds_fn(com, int'(mn), int'(mx), m_val, m_blink, m_peak);
      if (m_bcnt == BDIV - 1) begin m_bcnt = 0; m_blink = ~m_blink; end
      else m_bcnt++;
      e.blink = m_blink;
      if (pc) begin m_peak = 0; m_hold = 0; end
      else if (vv && int'(vl) >= m_peak) begin m_peak = int'(vl); m_hold = HOLD; end
      else if (m_hold > 1) m_hold--;
      else if (m_hold == 1) begin m_hold = 0; m_peak = m_val; end
      if (vv) m_val = int'(vl);
    end
    e.tgt = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    while (q.size() > 0 && q[0].tgt <= cyc) begin
      e = q.pop_front();
      chk("sb_leds", leds_o, e.leds);
      chk("sb_blink", 16'(blink_o), 16'(e.blink));
    end
  endtask

  task automatic load(input logic [3:0] v);
    vl = v; vv = 1'b1; tick(); vv = 1'b0;
  endtask

  initial begin
    logic b;
    int   n;
    m_val = 0; m_peak = 0; m_hold = 0; m_bcnt = 0; m_blink = 1'b0;
    rst = 1'b1; vv = 1'b0; pc = 1'b0; com = 3'd0; mn = 4'd0; mx = 4'd0; vl = 4'd0;
    tick();
    chk("rst_leds", leds_o, 16'h0000);
    chk("rst_blink", 16'(blink_o), 16'h0);
    rst = 1'b0;

    // idle: blink period 8, first high after the 4th edge
    com = 3'd2;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_leds", leds_o, 16'h0000);
      chk("idle_blink", 16'(blink_o), 16'(((i + 1) / 4) % 2));
    end

    // range mode, both blink phases
    com = 3'd0; mn = 4'd3; mx = 4'd12;
    load(4'd8);
    for (int i = 0; i < 8; i++) begin
      b = blink_o;
      tick();
      chk("range_8", leds_o, b ? 16'h1FF8 : 16'h01F8);
    end
    mn = 4'd9;  tick(); chk("range_below_min", leds_o, 16'h0000);
    mn = 4'd13; mx = 4'd2; tick(); chk("range_inverted", leds_o, 16'h0000);
    mn = 4'd5;  mx = 4'd5; load(4'd5); tick(); chk("range_single", leds_o, 16'h0020);
    mn = 4'd0;  mx = 4'd15; load(4'd15); tick(); chk("range_top", leds_o, 16'hFFFF);

    // bar and constant modes
    com = 3'd1;
    load(4'd0);  tick(); chk("bar_0", leds_o, 16'h0001);
    load(4'd15); tick(); chk("bar_15", leds_o, 16'hFFFF);
    com = 3'd2; tick(); chk("mode_010", leds_o, 16'h0000);
    com = 3'd3; tick(); chk("mode_011", leds_o, 16'hFFFF);
    com = 3'd7; tick(); chk("mode_111", leds_o, 16'h0000);

    // peak hold and fall-back
    pc = 1'b1; tick(); pc = 1'b0;
    com = 3'd4;
    load(4'd9);
    repeat (3) tick();
    load(4'd4);
    for (int k = 5; k <= 9; k++) begin
      tick();
      chk(k <= 8 ? "peak_hold" : "peak_fall", leds_o, k <= 8 ? 16'h021F : 16'h001F);
    end

    // reload before expiry restarts the hold
    load(4'd9);
    repeat (4) tick();
    load(4'd9);
    load(4'd4);
    for (int k = 7; k <= 14; k++) begin
      tick();
      if (k == 9)  chk("peak_restart_hold", leds_o, 16'h021F);
      if (k == 14) chk("peak_restart_fall", leds_o, 16'h001F);
    end

    // clear wins over capture, value still loads
    pc = 1'b1; vl = 4'd10; vv = 1'b1; tick();
    pc = 1'b0; vv = 1'b0; tick();
    chk("clr_vs_load", leds_o, 16'h07FF);

    // reset mid-hold while blink is high
    vl = 4'd9; vv = 1'b1; tick();
    n = 0;
    while (blink_o !== 1'b1 && n < 12) begin tick(); n++; end
    chk("wait_blink", 16'(blink_o), 16'h1);
    rst = 1'b1; tick();
    chk("midrst_leds", leds_o, 16'h0000);
    chk("midrst_blink", 16'(blink_o), 16'h0);
    rst = 1'b0; vv = 1'b0;
    load(4'd5); tick();
    chk("post_rst_peak", leds_o, 16'h003F);
    load(4'd3);
    repeat (10) tick();

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
